// File: rtl/tcore_param.sv
// Shared trap/writeback definitions: exception types, cause codes and the
// trap sequencing state encoding.
package tcore_param;

  typedef enum logic [3:0] {
    NO_EXCEPTION           = 4'd0,
    EXC_INSTR_ACCESS_FAULT = 4'd1,
    EXC_ILLEGAL            = 4'd2,
    EXC_EBREAK             = 4'd3,
    EXC_LOAD_MIS           = 4'd4,
    EXC_LOAD_FAULT         = 4'd5,
    EXC_STORE_MIS          = 4'd6,
    EXC_STORE_FAULT        = 4'd7,
    EXC_ECALL              = 4'd8
  } exc_type_e;

  localparam logic [4:0] CAUSE_INSTR_ACCESS_FAULT = 5'd1;
  localparam logic [4:0] CAUSE_ILLEGAL            = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK             = 5'd3;
  localparam logic [4:0] CAUSE_LOAD_MIS           = 5'd4;
  localparam logic [4:0] CAUSE_LOAD_FAULT         = 5'd5;
  localparam logic [4:0] CAUSE_STORE_MIS          = 5'd6;
  localparam logic [4:0] CAUSE_STORE_FAULT        = 5'd7;
  localparam logic [4:0] CAUSE_ECALL              = 5'd11;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

endpackage

// File: rtl/stage5_trap_writeback.sv
// Writeback stage with trap/mret sequencing (flush, then redirect).
// Optional interrupt entry and vectored mtvec enabled by TCORE_IRQ_EN.
module stage5_trap_writeback
  import tcore_param::*;
#(
  parameter int XLEN      = 32,
  parameter int FLUSH_CYC = 2,
  parameter int NUM_IRQ   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic [1:0]        data_sel_i,
  input  logic              is_comp_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   read_data_i,
  input  logic              rf_rw_en_i,
  input  logic [4:0]        rd_addr_i,
  input  exc_type_e         exc_type_i,
  input  logic [XLEN-1:0]   exc_tval_i,
  input  logic              mret_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic              mie_i,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              trap_we_o,
  output logic [XLEN-1:0]   trap_cause_o,
  output logic [XLEN-1:0]   trap_mepc_o,
  output logic [XLEN-1:0]   trap_mtval_o,
  output logic              flush_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              busy_o
);

  trap_state_e     state;
  logic [2:0]      cnt;
  logic [XLEN-1:0] target;

  logic            accept;
  logic            exc_taken;
  logic            irq_taken;
  logic [4:0]      exc_code;
  logic            exc_unknown;
  logic [4:0]      irq_code;
  logic [XLEN-1:0] cause_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] wb_data_c;

  assign accept = valid_i && !stall_i && (state == ST_IDLE);

  always_comb begin
    exc_taken   = (exc_type_i != NO_EXCEPTION);
    exc_code    = '0;
    exc_unknown = 1'b0;
    case (exc_type_i)
      EXC_INSTR_ACCESS_FAULT: exc_code = CAUSE_INSTR_ACCESS_FAULT;
      EXC_ILLEGAL:            exc_code = CAUSE_ILLEGAL;
      EXC_EBREAK:             exc_code = CAUSE_EBREAK;
      EXC_LOAD_MIS:           exc_code = CAUSE_LOAD_MIS;
      EXC_LOAD_FAULT:         exc_code = CAUSE_LOAD_FAULT;
      EXC_STORE_MIS:          exc_code = CAUSE_STORE_MIS;
      EXC_STORE_FAULT:        exc_code = CAUSE_STORE_FAULT;
      EXC_ECALL:              exc_code = CAUSE_ECALL;
      NO_EXCEPTION:           exc_code = '0;
      default:                exc_unknown = 1'b1;
    endcase
  end

`ifdef TCORE_IRQ_EN
  // Line priority is MEI > MSI > MTI, which is not bit order.
  always_comb begin
    irq_taken = mie_i && (|irq_i);
    if (irq_i[2])      irq_code = CAUSE_MEI;
    else if (irq_i[0]) irq_code = CAUSE_MSI;
    else               irq_code = CAUSE_MTI;
  end
`else
  logic unused_irq;
  assign unused_irq = ^{irq_i, mie_i, mtvec_i[1:0]};
  assign irq_taken  = 1'b0;
  assign irq_code   = '0;
`endif

  always_comb begin
    cause_c  = '0;
    target_c = {mtvec_i[XLEN-1:2], 2'b00};
    if (exc_taken) begin
      if (exc_unknown) cause_c = '1;
      else             cause_c[4:0] = exc_code;
    end else begin
      cause_c[4:0]      = irq_code;
      cause_c[XLEN-1]   = 1'b1;
`ifdef TCORE_IRQ_EN
      if (mtvec_i[1:0] == 2'b01)
        target_c = {mtvec_i[XLEN-1:2], 2'b00} + (XLEN'(irq_code) << 2);
`endif
    end
  end

  always_comb begin
    if (data_sel_i[1])      wb_data_c = pc_i + (is_comp_i ? XLEN'(2) : XLEN'(4));
    else if (data_sel_i[0]) wb_data_c = read_data_i;
    else                    wb_data_c = alu_result_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      target        <= '0;
      rf_we_o       <= 1'b0;
      rf_waddr_o    <= '0;
      wb_data_o     <= '0;
      trap_we_o     <= 1'b0;
      trap_cause_o  <= '0;
      trap_mepc_o   <= '0;
      trap_mtval_o  <= '0;
      flush_o       <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      busy_o        <= 1'b0;
    end else begin
      rf_we_o   <= 1'b0;
      trap_we_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (exc_taken || irq_taken || mret_i) begin
              state   <= ST_FLUSH;
              cnt     <= 3'(FLUSH_CYC - 1);
              flush_o <= 1'b1;
              busy_o  <= 1'b1;
            end
            if (exc_taken || irq_taken) begin
              trap_we_o    <= 1'b1;
              trap_cause_o <= cause_c;
              trap_mepc_o  <= pc_i;
              trap_mtval_o <= exc_taken ? exc_tval_i : '0;
              target       <= target_c;
            end else if (mret_i) begin
              target <= mepc_i;
            end else begin
              rf_we_o    <= rf_rw_en_i && (rd_addr_i != 5'd0);
              rf_waddr_o <= rd_addr_i;
              wb_data_o  <= wb_data_c;
            end
          end
        end
        ST_FLUSH: begin
          if (cnt == 3'd0) begin
            state         <= ST_REDIRECT;
            flush_o       <= 1'b0;
            redirect_o    <= 1'b1;
            redirect_pc_o <= target;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_REDIRECT: begin
          state         <= ST_IDLE;
          redirect_o    <= 1'b0;
          redirect_pc_o <= '0;
          busy_o        <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage5_trap_writeback.sv
// Randomized bench for stage5_trap_writeback with a cycle-position reference model.
module tb_stage5_trap_writeback;
  import tcore_param::*;

  localparam int FLUSH_CYC = 2;
`ifdef TCORE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, valid, stall, is_comp, rf_en, mret, mie;
  logic [1:0]  sel;
  logic [31:0] pc, alu, rdata, tval, mtvec, mepc;
  logic [4:0]  rd;
  logic [3:0]  exc_raw;
  logic [2:0]  irq;

  logic        rf_we_o, trap_we_o, flush_o, redirect_o, busy_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] wb_data_o, trap_cause_o, trap_mepc_o, trap_mtval_o, redirect_pc_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: cycles elapsed since a trap/mret was accepted (0 = idle).
  int          m_pos = 0;
  logic [31:0] m_target;
  logic        e_rf_we, e_trap_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata, e_cause, e_mepc, e_mtval;
  int          code_tab [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 11};

  stage5_trap_writeback #(.XLEN(32), .FLUSH_CYC(FLUSH_CYC), .NUM_IRQ(3)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall),
    .data_sel_i(sel), .is_comp_i(is_comp), .pc_i(pc), .alu_result_i(alu),
    .read_data_i(rdata), .rf_rw_en_i(rf_en), .rd_addr_i(rd),
    .exc_type_i(exc_type_e'(exc_raw)), .exc_tval_i(tval), .mret_i(mret),
    .mtvec_i(mtvec), .mepc_i(mepc), .irq_i(irq), .mie_i(mie),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .wb_data_o(wb_data_o),
    .trap_we_o(trap_we_o), .trap_cause_o(trap_cause_o), .trap_mepc_o(trap_mepc_o),
    .trap_mtval_o(trap_mtval_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int code;
    e_rf_we   = 1'b0;
    e_trap_we = 1'b0;
    if (rst) begin
      m_pos = 0;
      return;
    end
    if (m_pos != 0) begin
      m_pos++;
      if (m_pos > FLUSH_CYC + 1) m_pos = 0;
    end else if (valid && !stall) begin
      if (exc_raw != 4'd0) begin
        e_trap_we = 1'b1;
        e_cause   = (exc_raw <= 4'd8) ? 32'(code_tab[exc_raw]) : 32'hFFFF_FFFF;
        e_mepc    = pc;
        e_mtval   = tval;
        m_target  = mtvec & 32'hFFFF_FFFC;
        m_pos     = 1;
      end else if (IRQ_EN && mie && irq != 3'd0) begin
        code      = irq[2] ? 11 : (irq[0] ? 3 : 7);
        e_trap_we = 1'b1;
        e_cause   = 32'h8000_0000 + 32'(code);
        e_mepc    = pc;
        e_mtval   = 32'd0;
        m_target  = (mtvec & 32'hFFFF_FFFC) + ((mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'd0);
        m_pos     = 1;
      end else if (mret) begin
        m_target = mepc;
        m_pos    = 1;
      end else begin
        e_rf_we = rf_en && (rd != 5'd0);
        e_waddr = rd;
        if (sel[1])      e_wdata = pc + (is_comp ? 32'd2 : 32'd4);
        else if (sel[0]) e_wdata = rdata;
        else             e_wdata = alu;
      end
    end
  endtask

  task automatic compare_all();
    logic e_redir;
    e_redir = (m_pos == FLUSH_CYC + 1);
    check_val("rf_we", 32'(rf_we_o), 32'(e_rf_we));
    if (e_rf_we) begin
      check_val("rf_waddr", 32'(rf_waddr_o), 32'(e_waddr));
      check_val("wb_data", wb_data_o, e_wdata);
    end
    check_val("trap_we", 32'(trap_we_o), 32'(e_trap_we));
    if (e_trap_we) begin
      check_val("cause", trap_cause_o, e_cause);
      check_val("mepc", trap_mepc_o, e_mepc);
      check_val("mtval", trap_mtval_o, e_mtval);
    end
    check_val("flush", 32'(flush_o), 32'(m_pos >= 1 && m_pos <= FLUSH_CYC));
    check_val("redirect", 32'(redirect_o), 32'(e_redir));
    check_val("redirect_pc", redirect_pc_o, e_redir ? m_target : 32'd0);
    check_val("busy", 32'(busy_o), 32'(m_pos != 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    valid = 0; stall = 0; sel = 2'b00; is_comp = 0; rf_en = 0; rd = 0;
    pc = 32'h8000_0000; alu = 0; rdata = 0; tval = 0; exc_raw = 0; mret = 0;
    mtvec = 32'h8000_0100; mepc = 0; irq = 0; mie = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12 && m_pos != 0; i++) step();
  endtask

  initial begin
    int flush_cnt;
    int redir_seen;
    quiet();
    rst = 1;
    step();
    step();
    check_val("rst_cause", trap_cause_o, 32'd0);
    check_val("rst_wbdata", wb_data_o, 32'd0);
    rst = 0;

    // ALU writeback
    valid = 1; rf_en = 1; rd = 5'd5; alu = 32'h1234; sel = 2'b00;
    step();
    check_val("d_alu_we", 32'(rf_we_o), 32'd1);
    check_val("d_alu_data", wb_data_o, 32'h1234);
    quiet(); step();

    // ILLEGAL trap, flush length and redirect target
    valid = 1; exc_raw = 4'(EXC_ILLEGAL); pc = 32'h8000_0010; tval = 32'hFFFF_FFFF;
    mtvec = 32'h8000_0100; rf_en = 1; rd = 5'd3;
    step();
    check_val("d_ill_cause", trap_cause_o, 32'd2);
    check_val("d_ill_mtval", trap_mtval_o, 32'hFFFF_FFFF);
    quiet();
    flush_cnt = 0; redir_seen = 0;
    if (flush_o) flush_cnt++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (flush_o) flush_cnt++;
      if (redirect_o) begin
        redir_seen++;
        check_val("d_ill_target", redirect_pc_o, 32'h8000_0100);
      end
    end
    check_val("d_ill_flushcnt", 32'(flush_cnt), 32'(FLUSH_CYC));
    check_val("d_ill_redir", 32'(redir_seen), 32'd1);

    // ECALL beats an interrupt
    valid = 1; exc_raw = 4'(EXC_ECALL); irq = 3'b001; mie = 1;
    step();
    check_val("d_ecall_cause", trap_cause_o, 32'd11);
    quiet(); wait_idle();

`ifdef TCORE_IRQ_EN
    valid = 1; mie = 1; irq = 3'b110; mtvec = 32'h8000_0101; rf_en = 1; rd = 5'd7;
    step();
    check_val("d_irq_cause", trap_cause_o, 32'h8000_000B);
    check_val("d_irq_rfwe", 32'(rf_we_o), 32'd0);
    quiet(); mtvec = 32'h8000_0101;
    for (int i = 0; i < FLUSH_CYC; i++) step();
    check_val("d_irq_target", redirect_pc_o, 32'h8000_012C);
    quiet(); wait_idle();
`endif

    // Unknown exception encoding
    valid = 1; exc_raw = 4'hE;
    step();
    check_val("d_unk_cause", trap_cause_o, 32'hFFFF_FFFF);
    quiet(); wait_idle();

    // mret, then reset during flush aborts the redirect
    valid = 1; mret = 1; mepc = 32'h8000_0044;
    step();
    check_val("d_mret_trapwe", 32'(trap_we_o), 32'd0);
    quiet();
    for (int i = 0; i < FLUSH_CYC; i++) step();
    check_val("d_mret_target", redirect_pc_o, 32'h8000_0044);
    wait_idle();
    valid = 1; mret = 1; mepc = 32'h8000_0044;
    step();
    quiet(); rst = 1;
    step();
    check_val("d_rst_flush", 32'(flush_o), 32'd0);
    rst = 0;
    for (int i = 0; i < 5; i++) step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 99) < 2);
      valid   = ($urandom_range(0, 99) < 70);
      stall   = ($urandom_range(0, 99) < 20);
      sel     = 2'($urandom);
      is_comp = 1'($urandom);
      rf_en   = 1'($urandom);
      rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      pc      = $urandom & 32'hFFFF_FFFE;
      alu     = $urandom;
      rdata   = $urandom;
      tval    = $urandom;
      mtvec   = $urandom;
      mepc    = $urandom;
      mret    = ($urandom_range(0, 99) < 10);
      irq     = 3'($urandom);
      mie     = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 15)
        exc_raw = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(1, 8));
      else
        exc_raw = 4'd0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stage5_trap_writeback.md
STAGE5_TRAP_WRITEBACK -- requirements
Module: stage5_trap_writeback

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter FLUSH_CYC, default 2, legal 1..7: flush cycles between trap or mret acceptance and redirect.
REQ-003 Parameter NUM_IRQ, default 3: interrupt lines; bit0 = MSI (code 3), bit1 = MTI (code 7), bit2 = MEI (code 11).
REQ-004 One clock; reset is synchronous and active-high. clk_i input 1: clock. rst_i input 1: synchronous active-high reset.
REQ-005 valid_i in 1: instruction present in WB. stall_i in 1: hold WB. data_sel_i in 2: result select. is_comp_i in 1: compressed instruction.
REQ-006 pc_i in XLEN; alu_result_i in XLEN; read_data_i in XLEN; rf_rw_en_i in 1; rd_addr_i in 5.
REQ-007 exc_type_i in exc_type_e; exc_tval_i in XLEN: faulting address or instruction; mret_i in 1.
REQ-008 mtvec_i in XLEN; mepc_i in XLEN: CSR values. irq_i in NUM_IRQ: pending and enabled lines. mie_i in 1: global MIE.
REQ-009 rf_we_o out 1; rf_waddr_o out 5; wb_data_o out XLEN: registered regfile write.
REQ-010 trap_we_o out 1: one-cycle CSR update strobe. trap_cause_o, trap_mepc_o, trap_mtval_o out XLEN.
REQ-011 flush_o out 1; redirect_o out 1; redirect_pc_o out XLEN; busy_o out 1: FSM not IDLE.

Function
REQ-012 Accept condition: valid_i && !stall_i && state==IDLE; all outputs are registered, latency 1 cycle from accept.
REQ-013 Normal accept: rf_we_o = rf_rw_en_i && rd_addr_i!=0; wb_data_o selects pc+2 or pc+4 (per is_comp_i) when data_sel_i[1]=1, else read_data_i when data_sel_i[0]=1, else alu_result_i.
REQ-014 Priority at accept: exception > interrupt > mret > normal.
REQ-015 Exception: rf_we_o=0; trap_we_o=1; cause codes INSTR_ACCESS_FAULT=1, ILLEGAL=2, EBREAK=3, LOAD_MIS=4, LOAD_FAULT=5, STORE_MIS=6, STORE_FAULT=7, ECALL=11; cause[XLEN-1]=0; mepc=pc_i; mtval=exc_tval_i.
REQ-016 Interrupt (mie_i=1, irq_i!=0, no exception): instruction not retired, rf_we_o=0; cause[XLEN-1]=1; code from highest-priority line, MEI > MSI > MTI; mepc=pc_i; mtval=0.
REQ-017 Trap target: mtvec_i[1:0]==01 with interrupt gives {mtvec_i[XLEN-1:2],2'b00}+4*code; otherwise {mtvec_i[XLEN-1:2],2'b00}.
REQ-018 mret: rf_we_o=0, trap_we_o=0, target=mepc_i sampled at accept.
REQ-019 FSM IDLE -> FLUSH on trap/mret accept; FLUSH holds flush_o=1 for exactly FLUSH_CYC cycles, counted by a 3-bit counter; FLUSH -> REDIRECT; REDIRECT drives redirect_o=1 with redirect_pc_o=target for one cycle; REDIRECT -> IDLE.
REQ-020 Outside IDLE, valid_i, irq_i and mret_i are ignored and rf_we_o=0; stall_i has no effect on FLUSH/REDIRECT progress.
REQ-021 With stall_i=1 in IDLE: no accept; rf_we_o=0, trap_we_o=0.
REQ-022 Exception with exc_type_i==NO_EXCEPTION never occurs; a default enum value produces cause all-ones with trap taken.

Reset
REQ-023 rst_i=1 at any clock edge forces IDLE, counter 0, and all outputs 0, aborting any flush or redirect in progress; no redirect follows.

Configuration
REQ-024 Macro TCORE_IRQ_EN defined: REQ-016 and the vectored path of REQ-017 are active; undefined: irq_i and mie_i are ignored and mtvec is always direct.

Structure
REQ-025 exc_type_e, the cause-code localparams and the trap FSM state enum reside in tcore_param; no sub-module is required.

Verification
REQ-026 ALU op, data_sel_i=00, rd=5, alu=0x1234 -> next cycle rf_we_o=1, waddr=5, data=0x1234, no flush.
REQ-027 ILLEGAL at pc=0x80000010, tval=0xFFFFFFFF, mtvec=0x80000100 -> trap_we_o pulse, cause=2, mtval=0xFFFFFFFF, flush_o high 2 cycles, redirect to 0x80000100.
REQ-028 TCORE_IRQ_EN, mie_i=1, irq_i=3'b110, mtvec=0x80000101 -> cause=0x8000000B, redirect to 0x8000012C, rf_we_o=0.
REQ-029 ECALL together with irq_i=3'b001 -> cause=11 (exception wins).
REQ-030 mret_i, mepc_i=0x80000044 -> no trap_we_o, redirect_pc_o=0x80000044 after FLUSH_CYC; rst_i asserted during FLUSH -> no redirect, outputs 0.
